bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 25 ++
 rtl/bus_arbiter_if.sv | 25 ++
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the icache/dcache bus arbiter.
package bus_arb_pkg;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANTED    = 2'd1,
      READ_RESP  = 2'd2,
      WRITE_DATA = 2'd3
   } arb_state_e;

   // Current (or last) bus owner.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   localparam int BEATS_PER_LINE  = 8;
   localparam int WR_TAG_BIT      = 12;
   localparam int WATCHDOG_CYCLES = 16;
   localparam int BEAT_CNT_WIDTH  = 4;
   localparam int WD_CNT_WIDTH    = $clog2(WATCHDOG_CYCLES);

endpackage

// File: rtl/bus_arbiter_if.sv
// One request/response bus link. The master side issues requests and
// acknowledges responses; the slave side accepts requests and returns data.
interface bus_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 13
);
   logic                  reqcyc;
   logic [DATA_WIDTH-1:0] req;
   logic [TAG_WIDTH-1:0]  reqtag;
   logic                  respack;
   logic                  reqack;
   logic                  respcyc;
   logic [DATA_WIDTH-1:0] resp;
   logic [TAG_WIDTH-1:0]  resptag;

   modport master (
      output reqcyc, req, reqtag, respack,
      input  reqack, respcyc, resp, resptag
   );

   modport slave (
      input  reqcyc, req, reqtag, respack,
      output reqack, respcyc, resp, resptag
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester (icache/dcache) arbiter for a single system bus. Ownership
// is granted round-robin from IDLE and held for one full line transfer
// (8 beats read or write), or until the idle watchdog fires.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_bus_assert,
   input  logic          d_bus_assert,
   output logic          i_has_bus,
   output logic          d_has_bus,
   bus_arbiter_if.slave  i_bus,
   bus_arbiter_if.slave  d_bus,
   bus_arbiter_if.master sys_bus
);

   localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_LAST = BEAT_CNT_WIDTH'(BEATS_PER_LINE - 1);
   localparam logic [WD_CNT_WIDTH-1:0]   WD_LAST   = WD_CNT_WIDTH'(WATCHDOG_CYCLES - 1);

   arb_state_e                state_reg;
   owner_e                    owner_reg;
   owner_e                    last_grant_reg;
   logic [BEAT_CNT_WIDTH-1:0] beat_cnt_reg;
   logic [WD_CNT_WIDTH-1:0]   wd_cnt_reg;
   logic                      i_has_bus_reg;
   logic                      d_has_bus_reg;

   logic                      owner_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] owner_req;
   logic [BUS_TAG_WIDTH-1:0]  owner_reqtag;
   logic                      owner_respack;
   logic                      resp_phase;

   // Responses are only meaningful once a request has been accepted.
   assign resp_phase = (state_reg == READ_RESP) || (state_reg == WRITE_DATA);

   // Route the owner's request onto the bus and the bus responses back to the owner only.
   always_comb begin
      owner_reqcyc   = 1'b0;
      owner_req      = '0;
      owner_reqtag   = '0;
      owner_respack  = 1'b0;
      i_bus.reqack   = 1'b0;
      i_bus.respcyc  = 1'b0;
      i_bus.resp     = '0;
      i_bus.resptag  = '0;
      d_bus.reqack   = 1'b0;
      d_bus.respcyc  = 1'b0;
      d_bus.resp     = '0;
      d_bus.resptag  = '0;
      case (owner_reg)
         OWN_I: begin
            owner_reqcyc  = i_bus.reqcyc;
            owner_req     = i_bus.req;
            owner_reqtag  = i_bus.reqtag;
            owner_respack = i_bus.respack;
            i_bus.reqack  = sys_bus.reqack;
            i_bus.respcyc = resp_phase & sys_bus.respcyc;
            if (resp_phase) begin
               i_bus.resp    = sys_bus.resp;
               i_bus.resptag = sys_bus.resptag;
            end
         end
         OWN_D: begin
            owner_reqcyc  = d_bus.reqcyc;
            owner_req     = d_bus.req;
            owner_reqtag  = d_bus.reqtag;
            owner_respack = d_bus.respack;
            d_bus.reqack  = sys_bus.reqack;
            d_bus.respcyc = resp_phase & sys_bus.respcyc;
            if (resp_phase) begin
               d_bus.resp    = sys_bus.resp;
               d_bus.resptag = sys_bus.resptag;
            end
         end
         default: ;
      endcase
   end

   assign sys_bus.reqcyc  = owner_reqcyc;
   assign sys_bus.req     = owner_req;
   assign sys_bus.reqtag  = owner_reqtag;
   assign sys_bus.respack = owner_respack;
   assign i_has_bus       = i_has_bus_reg;
   assign d_has_bus       = d_has_bus_reg;

   // Grant FSM: owner selection, beat counting, watchdog and registered grants.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= OWN_NONE;
         last_grant_reg <= OWN_I;
         beat_cnt_reg   <= '0;
         wd_cnt_reg     <= '0;
         i_has_bus_reg  <= 1'b0;
         d_has_bus_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               wd_cnt_reg <= '0;
               // dcache wins a tie unless it was the last owner.
               if (d_bus_assert && (!i_bus_assert || last_grant_reg == OWN_I)) begin
                  owner_reg      <= OWN_D;
                  last_grant_reg <= OWN_D;
                  d_has_bus_reg  <= 1'b1;
                  state_reg      <= GRANTED;
               end else if (i_bus_assert) begin
                  owner_reg      <= OWN_I;
                  last_grant_reg <= OWN_I;
                  i_has_bus_reg  <= 1'b1;
                  state_reg      <= GRANTED;
               end
            end
            GRANTED: begin
               if (owner_reqcyc && sys_bus.reqack) begin
                  beat_cnt_reg <= '0;
                  wd_cnt_reg   <= '0;
                  state_reg    <= owner_reqtag[WR_TAG_BIT] ? WRITE_DATA : READ_RESP;
               end else if (owner_reqcyc) begin
                  wd_cnt_reg <= '0;
               end else if (wd_cnt_reg == WD_LAST) begin
                  state_reg     <= IDLE;
                  owner_reg     <= OWN_NONE;
                  i_has_bus_reg <= 1'b0;
                  d_has_bus_reg <= 1'b0;
                  wd_cnt_reg    <= '0;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + 1'b1;
               end
            end
            READ_RESP, WRITE_DATA: begin
               // Reads count response beats, writes count the owner's data beats.
               if ((state_reg == READ_RESP) ? sys_bus.respcyc : owner_reqcyc) begin
                  if (beat_cnt_reg == BEAT_LAST) begin
                     state_reg     <= IDLE;
                     owner_reg     <= OWN_NONE;
                     i_has_bus_reg <= 1'b0;
                     d_has_bus_reg <= 1'b0;
                     beat_cnt_reg  <= '0;
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + 1'b1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table for grant,
// routing, read and write transfers, plus watchdog and reset sequences.
module tb_bus_arbiter;
   import bus_arb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic i_bus_assert, d_bus_assert;
   logic i_has_bus, d_has_bus;

   bus_arbiter_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) i_if ();
   bus_arbiter_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) d_if ();
   bus_arbiter_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) sys_if ();

   bus_arbiter #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_bus_assert (i_bus_assert),
      .d_bus_assert (d_bus_assert),
      .i_has_bus    (i_has_bus),
      .d_has_bus    (d_has_bus),
      .i_bus        (i_if),
      .d_bus        (d_if),
      .sys_bus      (sys_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ia, da;
      logic        irc;
      logic [12:0] itag;
      logic [63:0] ireq;
      logic        drc;
      logic [12:0] dtag;
      logic [63:0] dreq;
      logic        ack, rcyc;
      logic [63:0] rdata;
      logic        x_ih, x_dh, x_brc;
      logic [63:0] x_breq;
      logic [12:0] x_btag;
      logic        x_iack, x_dack, x_irc;
      logic [63:0] x_iresp;
      logic        x_drc;
      logic [63:0] x_dresp;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [63:0] IQ  = 64'hAAAA_0000_0000_0001;
   localparam logic [63:0] DQ  = 64'hDDDD_0000_0000_00D0;
   localparam logic [63:0] WB  = 64'hBEEF_0000_0000_0000;
   localparam logic [12:0] TRD = 13'h0100;
   localparam logic [12:0] TWR = 13'h1100;
   localparam logic [12:0] TIR = 13'h0200;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic ia, da, irc, input logic [12:0] itag, input logic [63:0] ireq,
                      input logic drc, input logic [12:0] dtag, input logic [63:0] dreq,
                      input logic ack, rcyc, input logic [63:0] rdata,
                      input logic x_ih, x_dh, x_brc, input logic [63:0] x_breq, input logic [12:0] x_btag,
                      input logic x_iack, x_dack, x_irc, input logic [63:0] x_iresp,
                      input logic x_drc, input logic [63:0] x_dresp);
      vec_t v;
      v.ia = ia; v.da = da; v.irc = irc; v.itag = itag; v.ireq = ireq;
      v.drc = drc; v.dtag = dtag; v.dreq = dreq;
      v.ack = ack; v.rcyc = rcyc; v.rdata = rdata;
      v.x_ih = x_ih; v.x_dh = x_dh; v.x_brc = x_brc; v.x_breq = x_breq; v.x_btag = x_btag;
      v.x_iack = x_iack; v.x_dack = x_dack; v.x_irc = x_irc; v.x_iresp = x_iresp;
      v.x_drc = x_drc; v.x_dresp = x_dresp;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic ia, da, irc, input logic [63:0] ireq, input logic [12:0] itag,
                        input logic drc, input logic [63:0] dreq, input logic [12:0] dtag,
                        input logic ack, rcyc, input logic [63:0] rdata);
      i_bus_assert   = ia;
      d_bus_assert   = da;
      i_if.reqcyc    = irc;
      i_if.req       = ireq;
      i_if.reqtag    = itag;
      i_if.respack   = 1'b0;
      d_if.reqcyc    = drc;
      d_if.req       = dreq;
      d_if.reqtag    = dtag;
      d_if.respack   = 1'b0;
      sys_if.reqack  = ack;
      sys_if.respcyc = rcyc;
      sys_if.resp    = rdata;
      sys_if.resptag = rcyc ? 13'h0100 : 13'h0000;
   endtask

   // Advance to the next cycle; inputs change just after the rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with busy-looking inputs: nothing may be granted or routed.
      reset = 1'b1;
      drive(1, 1, 1, IQ, TIR, 1, DQ, TRD, 1, 1, 64'h99);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset i_has_bus", 64'(i_has_bus), 64'd0);
      check("reset d_has_bus", 64'(d_has_bus), 64'd0);
      check("reset bus_reqcyc", 64'(sys_if.reqcyc), 64'd0);
      check("reset bus_req", sys_if.req, 64'd0);
      check("reset d_respcyc", 64'(d_if.respcyc), 64'd0);
      check("reset state", 64'(dut.state_reg), 64'(IDLE));
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Stray response beat while idle.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h77);
      @(negedge clk);
      check("stray i_respcyc", 64'(i_if.respcyc), 64'd0);
      check("stray d_respcyc", 64'(d_if.respcyc), 64'd0);
      check("stray d_resp", d_if.resp, 64'd0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("stray beat_cnt", 64'(dut.beat_cnt_reg), 64'd0);
      check("stray state", 64'(dut.state_reg), 64'(IDLE));
      $display("seq stray-idle-respcyc done");
      next_cycle();

      // Vector table: tie grant, dcache read, icache read, dcache write.
      add(1,1, 0,0,0,  1,TRD,DQ, 0,1,64'h55,  0,0, 0,0,0,      0,0, 0,0, 0,0);
      add(1,1, 0,0,0,  1,TRD,DQ, 0,1,64'h66,  0,1, 1,DQ,TRD,   0,0, 0,0, 0,0);
      add(1,0, 0,0,0,  1,TRD,DQ, 1,0,0,       0,1, 1,DQ,TRD,   0,1, 0,0, 0,0);
      for (int k = 1; k <= 4; k++)
         add(1,0, 0,0,0, 0,0,0, 0,1,64'(k*17), 0,1, 0,0,0, 0,0, 0,0, 1,64'(k*17));
      add(1,0, 0,0,0,  0,0,0,    0,0,0,       0,1, 0,0,0,      0,0, 0,0, 0,0);
      for (int k = 5; k <= 8; k++)
         add(1,0, 0,0,0, 0,0,0, 0,1,64'(k*17), 0,1, 0,0,0, 0,0, 0,0, 1,64'(k*17));
      add(1,0, 0,0,0,  0,0,0,    0,0,0,       0,0, 0,0,0,      0,0, 0,0, 0,0);
      add(1,0, 1,TIR,IQ, 1,TRD,DQ, 0,0,0,     1,0, 1,IQ,TIR,   0,0, 0,0, 0,0);
      add(1,0, 1,TIR,IQ, 1,TRD,DQ, 1,0,0,     1,0, 1,IQ,TIR,   1,0, 0,0, 0,0);
      for (int k = 1; k <= 8; k++)
         add(0,1, 0,0,0, 1,TRD,DQ, 0,1,64'h1000+64'(k), 1,0, 0,0,0, 0,0, 1,64'h1000+64'(k), 0,0);
      add(0,1, 0,0,0,  1,TRD,DQ, 0,0,0,       0,0, 0,0,0,      0,0, 0,0, 0,0);
      add(0,1, 0,0,0,  1,TWR,64'hADD0, 1,0,0, 0,1, 1,64'hADD0,TWR, 0,1, 0,0, 0,0);
      for (int k = 1; k <= 3; k++)
         add(0,0, 0,0,0, 1,TWR,WB+64'(k), 0,0,0, 0,1, 1,WB+64'(k),TWR, 0,0, 0,0, 0,0);
      add(0,0, 0,0,0,  0,TWR,0,  0,0,0,       0,1, 0,0,TWR,    0,0, 0,0, 0,0);
      for (int k = 4; k <= 8; k++)
         add(0,0, 0,0,0, 1,TWR,WB+64'(k), 0,0,0, 0,1, 1,WB+64'(k),TWR, 0,0, 0,0, 0,0);
      add(0,0, 0,0,0,  0,0,0,    0,0,0,       0,0, 0,0,0,      0,0, 0,0, 0,0);

      foreach (vecs[n]) begin
         drive(vecs[n].ia, vecs[n].da, vecs[n].irc, vecs[n].ireq, vecs[n].itag,
               vecs[n].drc, vecs[n].dreq, vecs[n].dtag,
               vecs[n].ack, vecs[n].rcyc, vecs[n].rdata);
         @(negedge clk);
         check($sformatf("v%0d i_has_bus", n), 64'(i_has_bus), 64'(vecs[n].x_ih));
         check($sformatf("v%0d d_has_bus", n), 64'(d_has_bus), 64'(vecs[n].x_dh));
         check($sformatf("v%0d bus_reqcyc", n), 64'(sys_if.reqcyc), 64'(vecs[n].x_brc));
         check($sformatf("v%0d bus_req", n), sys_if.req, vecs[n].x_breq);
         check($sformatf("v%0d bus_reqtag", n), 64'(sys_if.reqtag), 64'(vecs[n].x_btag));
         check($sformatf("v%0d i_reqack", n), 64'(i_if.reqack), 64'(vecs[n].x_iack));
         check($sformatf("v%0d d_reqack", n), 64'(d_if.reqack), 64'(vecs[n].x_dack));
         check($sformatf("v%0d i_respcyc", n), 64'(i_if.respcyc), 64'(vecs[n].x_irc));
         check($sformatf("v%0d i_resp", n), i_if.resp, vecs[n].x_iresp);
         check($sformatf("v%0d d_respcyc", n), 64'(d_if.respcyc), 64'(vecs[n].x_drc));
         check($sformatf("v%0d d_resp", n), d_if.resp, vecs[n].x_dresp);
         $display("vec %0d: i_has=%b d_has=%b bus_reqcyc=%b bus_req=%h d_respcyc=%b d_resp=%h",
                  n, i_has_bus, d_has_bus, sys_if.reqcyc, sys_if.req, d_if.respcyc, d_if.resp);
         next_cycle();
      end

      // Watchdog: icache granted, then never issues reqcyc.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("wd pre-grant i_has_bus", 64'(i_has_bus), 64'd0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         check($sformatf("wd cycle %0d i_has_bus", c), 64'(i_has_bus), 64'd1);
         next_cycle();
      end
      @(negedge clk);
      check("wd cycle 17 i_has_bus", 64'(i_has_bus), 64'd0);
      check("wd cycle 17 state", 64'(dut.state_reg), 64'(IDLE));
      $display("seq watchdog done");
      next_cycle();

      // Reset during beat 4 of a dcache read.
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, DQ, TRD, 1, 0, 0);
      @(negedge clk);
      check("rst grant d_has_bus", 64'(d_has_bus), 64'd1);
      next_cycle();
      for (int k = 1; k <= 3; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'(k));
         next_cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h4);
      reset = 1'b1;
      @(negedge clk);
      check("rst beat4 beat_cnt", 64'(dut.beat_cnt_reg), 64'd3);
      check("rst beat4 d_respcyc", 64'(d_if.respcyc), 64'd1);
      next_cycle();
      reset = 1'b0;
      drive(1, 0, 0, 0, 0, 1, DQ, TRD, 0, 1, 64'h5);
      @(negedge clk);
      check("rst after i_has_bus", 64'(i_has_bus), 64'd0);
      check("rst after d_has_bus", 64'(d_has_bus), 64'd0);
      check("rst after bus_reqcyc", 64'(sys_if.reqcyc), 64'd0);
      check("rst after bus_req", sys_if.req, 64'd0);
      check("rst after bus_reqtag", 64'(sys_if.reqtag), 64'd0);
      check("rst after d_respcyc", 64'(d_if.respcyc), 64'd0);
      check("rst after d_resp", d_if.resp, 64'd0);
      check("rst after beat_cnt", 64'(dut.beat_cnt_reg), 64'd0);
      check("rst after state", 64'(dut.state_reg), 64'(IDLE));
      next_cycle();
      drive(1, 0, 1, IQ, TIR, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("rst regrant i_has_bus", 64'(i_has_bus), 64'd1);
      check("rst regrant bus_req", sys_if.req, IQ);
      $display("seq reset-mid-read done");
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
